hex_msg_display: RTL and testbench

- Parametrised seven-segment display controller for the board's HEX bank. It generalises the fixed six-channel hex PIO exports to NUM_DIGITS digits.
- A software or FPGA producer loads a character message of up to MSG_DEPTH entries through a valid/ready port.
- The block renders the message in one of three modes: static, blink, or scroll (marquee with wrap-around).
- It sits between the PIO/hardware_out fabric and the hexN pins. Game logic can show scores and status text without CPU-timed refresh.

---
 rtl/hex_msg_display_pkg.sv | 25 ++
 rtl/hex_msg_display_if.sv | 21 ++
 rtl/hex_msg_display_decode.sv | 38 +++
 rtl/hex_msg_display.sv | 176 +++++++++++++++++
 tb/tb_hex_msg_display.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hex_msg_display_pkg.sv
// hex_msg_display shared types and constants.
// Character codes, display modes, blank segment pattern.
package hex_pkg;

  localparam logic [4:0] CH_BLANK = 5'h10;
  localparam logic [4:0] CH_MINUS = 5'h11;
  localparam logic [4:0] CH_N     = 5'h12;
  localparam logic [4:0] CH_R     = 5'h13;
  localparam logic [4:0] CH_L     = 5'h14;
  localparam logic [4:0] CH_P     = 5'h15;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_SCROLL = 2'd2
  } mode_e;

  function automatic int max2(input int a,
                              input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hex_msg_display_if.sv
// Character write port for hex_msg_display.
// Producer drives valid/data, display returns ready.
interface hex_msg_display_if;

  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_data;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/hex_msg_display_decode.sv
// Character code to active-low seven-segment pattern.
// Bit 0 is segment a, bit 6 is segment g.
module seg7_char_decode
  import hex_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    case (code)
      5'h00:    seg = 7'h40;
      5'h01:    seg = 7'h79;
      5'h02:    seg = 7'h24;
      5'h03:    seg = 7'h30;
      5'h04:    seg = 7'h19;
      5'h05:    seg = 7'h12;
      5'h06:    seg = 7'h02;
      5'h07:    seg = 7'h78;
      5'h08:    seg = 7'h00;
      5'h09:    seg = 7'h10;
      5'h0A:    seg = 7'h08;
      5'h0B:    seg = 7'h03;
      5'h0C:    seg = 7'h46;
      5'h0D:    seg = 7'h21;
      5'h0E:    seg = 7'h06;
      5'h0F:    seg = 7'h0E;
      CH_BLANK: seg = 7'h7F;
      CH_MINUS: seg = 7'h3F;
      CH_N:     seg = 7'h2B;
      CH_R:     seg = 7'h2F;
      CH_L:     seg = 7'h47;
      CH_P:     seg = 7'h0C;
      default:  seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_msg_display.sv
// Seven-segment message controller for the HEX bank.
// Static, blink and wrap-around scroll rendering.
module hex_msg_display
  import hex_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int MSG_DEPTH    = 16,
  parameter int SCROLL_TICKS = 12_500_000,
  parameter int BLINK_TICKS  = 25_000_000
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset_n,
  input  logic                         clr,
  hex_msg_display_if.slave             wr,
  input  logic [1:0]                   mode,
  input  logic [NUM_DIGITS-1:0]        dp_in,
  output logic [8*NUM_DIGITS-1:0]      hex_out,
  output logic [$clog2(MSG_DEPTH+1)-1:0] msg_len
);

  localparam int LW   = $clog2(MSG_DEPTH + 1);
  localparam int IW   = LW + 1;
  localparam int AW   = (MSG_DEPTH > 1) ?
                        $clog2(MSG_DEPTH) : 1;
  localparam int TMAX = max2(SCROLL_TICKS,
                             BLINK_TICKS);
  localparam int TW   = (TMAX > 1) ?
                        $clog2(TMAX) : 1;

  typedef logic [LW-1:0] len_t;
  typedef logic [TW-1:0] tmr_t;

  logic [4:0] msg_buf [MSG_DEPTH];

  len_t       len_q, len_d;
  len_t       off_q, off_d;
  tmr_t       stmr_q, stmr_d;
  tmr_t       btmr_q, btmr_d;
  logic       phase_q, phase_d;
  logic       live_q;
  logic [1:0] mode_q;

  mode_e      mode_eff;
  logic       accept;
  logic       mode_chg;
  logic       scroll_act;

  logic [IW-1:0] idx  [NUM_DIGITS];
  logic [4:0]    code [NUM_DIGITS];
  logic [6:0]    seg  [NUM_DIGITS];
  logic [8*NUM_DIGITS-1:0] hex_d;

  always_comb begin
    case (mode)
      2'd1:    mode_eff = MODE_BLINK;
      2'd2:    mode_eff = MODE_SCROLL;
      default: mode_eff = MODE_STATIC;
    endcase
  end

  assign wr.wr_ready = live_q && !clr &&
                       (len_q < len_t'(MSG_DEPTH));
  assign accept      = wr.wr_valid && wr.wr_ready;
  assign mode_chg    = (mode != mode_q);
  assign scroll_act  = (mode_eff == MODE_SCROLL) &&
                       (len_q > len_t'(NUM_DIGITS));
  assign msg_len     = len_q;

  always_comb begin
    len_d   = len_q;
    off_d   = off_q;
    stmr_d  = stmr_q;
    btmr_d  = btmr_q;
    phase_d = phase_q;

    if (clr)
      len_d = '0;
    else if (accept)
      len_d = len_q + 1'b1;

    if (mode_chg) begin
      off_d   = '0;
      stmr_d  = '0;
      btmr_d  = '0;
      phase_d = 1'b1;
    end else begin
      if (scroll_act) begin
        if (stmr_q == TW'(SCROLL_TICKS - 1)) begin
          stmr_d = '0;
          off_d  = (off_q >= len_q - 1'b1) ?
                   '0 : off_q + 1'b1;
        end else begin
          stmr_d = stmr_q + 1'b1;
        end
      end else begin
        stmr_d = '0;
        off_d  = '0;
      end

      if (mode_eff == MODE_BLINK) begin
        if (btmr_q == TW'(BLINK_TICKS - 1)) begin
          btmr_d  = '0;
          phase_d = !phase_q;
        end else begin
          btmr_d = btmr_q + 1'b1;
        end
      end else begin
        btmr_d  = '0;
        phase_d = 1'b1;
      end
    end

    // an emptied buffer can never hold a live scroll position
    if (clr)
      off_d = '0;
  end

  // position k (leftmost k=0) feeds digit NUM_DIGITS-1-k
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      idx[i] = {1'b0, off_q} +
               IW'(NUM_DIGITS - 1 - i);
      if (idx[i] >= IW'(len_q))
        idx[i] = idx[i] - IW'(len_q);
      if (len_q > len_t'(NUM_DIGITS))
        code[i] = msg_buf[idx[i][AW-1:0]];
      else if (IW'(NUM_DIGITS - 1 - i) < IW'(len_q))
        code[i] = msg_buf[AW'(NUM_DIGITS - 1 - i)];
      else
        code[i] = CH_BLANK;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_char_decode u_dec (
      .code (code[g]),
      .seg  (seg[g])
    );
  end

  always_comb begin
    hex_d = {NUM_DIGITS{SEG_BLANK}};
    if (!(mode_eff == MODE_BLINK && !phase_q)) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        hex_d[8*i +: 8] = {~dp_in[i], seg[i]};
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      len_q   <= '0;
      off_q   <= '0;
      stmr_q  <= '0;
      btmr_q  <= '0;
      phase_q <= 1'b1;
      live_q  <= 1'b0;
      mode_q  <= MODE_STATIC;
      hex_out <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      len_q   <= len_d;
      off_q   <= off_d;
      stmr_q  <= stmr_d;
      btmr_q  <= btmr_d;
      phase_q <= phase_d;
      live_q  <= 1'b1;
      mode_q  <= mode;
      hex_out <= hex_d;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset_n && accept)
      msg_buf[len_q[AW-1:0]] <= wr.wr_data;
  end

endmodule

// File: tb/tb_hex_msg_display.sv
// Scoreboard bench for hex_msg_display.
// Six digits, 16 entries, fast scroll and blink timers.
module tb_hex_msg_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [1:0]  mode;
  logic [5:0]  dp_in;
  logic [47:0] hex_out;
  logic [4:0]  msg_len;

  hex_msg_display_if wr_if ();

  hex_msg_display #(
    .NUM_DIGITS   (6),
    .MSG_DEPTH    (16),
    .SCROLL_TICKS (4),
    .BLINK_TICKS  (3)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .clr           (clr),
    .wr            (wr_if),
    .mode          (mode),
    .dp_in         (dp_in),
    .hex_out       (hex_out),
    .msg_len       (msg_len)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [47:0] exp_q [$];
  logic [47:0] e;
  logic [4:0]  m_buf [16];
  int          m_len = 0;

  function automatic logic [7:0] seg_tab(input int c);
    case (c)
      0: return 8'hC0;   1: return 8'hF9;
      2: return 8'hA4;   3: return 8'hB0;
      4: return 8'h99;   5: return 8'h92;
      6: return 8'h82;   7: return 8'hF8;
      8: return 8'h80;   9: return 8'h90;
      10: return 8'h88;  11: return 8'h83;
      12: return 8'hC6;  13: return 8'hA1;
      14: return 8'h86;  15: return 8'h8E;
      17: return 8'hBF;  18: return 8'hAB;
      19: return 8'hAF;  20: return 8'hC7;
      21: return 8'h8C;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [47:0] render(input int off,
                                         input logic [5:0] dp);
    logic [47:0] f;
    logic [7:0]  b;
    int          c;
    f = '0;
    for (int k = 0; k < 6; k++) begin
      if (m_len > 6)
        c = int'(m_buf[(off + k) % m_len]);
      else if (k < m_len)
        c = int'(m_buf[k]);
      else
        c = 16;
      b = seg_tab(c);
      b[7] = ~dp[5-k];
      f[8*(5-k) +: 8] = b;
    end
    return f;
  endfunction

  task automatic set_in(input bit v,
                        input logic [4:0] d,
                        input bit c);
    wr_if.wr_valid = v;
    wr_if.wr_data  = d;
    clr            = c;
    #1;
  endtask

  task automatic clk_step();
    exp_q.push_back(render(0, dp_in));
    @(posedge clk);
    #1;
    if (clr)
      m_len = 0;
    else if (wr_if.wr_valid && m_len < 16) begin
      m_buf[m_len] = wr_if.wr_data;
      m_len++;
    end
  endtask

  task automatic scroll_cycle(input int n);
    mode = 2'd2;
    exp_q.push_back(render((n == 0) ? 0 : (n - 1) / 4,
                           dp_in));
    @(posedge clk);
    #1;
  endtask

  task automatic leave_mode();
    mode = 2'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mode  = 2'd0;
    dp_in = '0;
    set_in(0, 5'd0, 0);
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (hex_out !== {6{8'hFF}})
      $display("FAIL reset_hex got %h want %h",
               hex_out, {6{8'hFF}});
    else pass_cnt++;
    total_cnt++;
    if (msg_len !== 5'd0)
      $display("FAIL reset_len got %0d want 0", msg_len);
    else pass_cnt++;
    total_cnt++;
    if (wr_if.wr_ready !== 1'b0)
      $display("FAIL reset_ready got %b want 0",
               wr_if.wr_ready);
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (wr_if.wr_ready !== 1'b1)
      $display("FAIL release_ready got %b want 1",
               wr_if.wr_ready);
    else pass_cnt++;
    m_len = 0;
    exp_q.delete();
  endtask

  task automatic test_static();
    for (int i = 1; i <= 3; i++) begin
      set_in(1, 5'(i), 0);
      total_cnt++;
      if (wr_if.wr_ready !== 1'b1)
        $display("FAIL static_ready got %b want 1",
                 wr_if.wr_ready);
      else pass_cnt++;
      clk_step();
      e = exp_q.pop_front();
      total_cnt++;
      if (hex_out !== e)
        $display("FAIL static_wr got %h want %h", hex_out, e);
      else pass_cnt++;
    end
    set_in(0, 5'd0, 0);
    clk_step();
    e = exp_q.pop_front();
    total_cnt++;
    if (hex_out !== e)
      $display("FAIL static_model got %h want %h", hex_out, e);
    else pass_cnt++;
    total_cnt++;
    if (hex_out !== 48'hF9A4B0FFFFFF)
      $display("FAIL static_123 got %h want %h",
               hex_out, 48'hF9A4B0FFFFFF);
    else pass_cnt++;
    total_cnt++;
    if (msg_len !== 5'd3)
      $display("FAIL static_len got %0d want 3", msg_len);
    else pass_cnt++;
  endtask

  task automatic test_clr_collision();
    logic [4:0] extra [2];
    extra[0] = 5'h11;
    extra[1] = 5'h15;
    for (int i = 0; i < 2; i++) begin
      set_in(1, extra[i], 0);
      clk_step();
      e = exp_q.pop_front();
      total_cnt++;
      if (hex_out !== e)
        $display("FAIL clr_fill got %h want %h", hex_out, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (msg_len !== 5'd5)
      $display("FAIL clr_pre_len got %0d want 5", msg_len);
    else pass_cnt++;
    set_in(1, 5'h04, 1);
    total_cnt++;
    if (wr_if.wr_ready !== 1'b0)
      $display("FAIL clr_ready got %b want 0", wr_if.wr_ready);
    else pass_cnt++;
    clk_step();
    e = exp_q.pop_front();
    total_cnt++;
    if (hex_out !== e)
      $display("FAIL clr_edge got %h want %h", hex_out, e);
    else pass_cnt++;
    total_cnt++;
    if (msg_len !== 5'd0)
      $display("FAIL clr_len got %0d want 0", msg_len);
    else pass_cnt++;
    set_in(0, 5'd0, 0);
    clk_step();
    e = exp_q.pop_front();
    total_cnt++;
    if (hex_out !== {6{8'hFF}})
      $display("FAIL clr_blank got %h want %h",
               hex_out, {6{8'hFF}});
    else pass_cnt++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      set_in(1, 5'(i), 0);
      total_cnt++;
      if (wr_if.wr_ready !== 1'b1)
        $display("FAIL full_ready_%0d got %b want 1",
                 i, wr_if.wr_ready);
      else pass_cnt++;
      clk_step();
      e = exp_q.pop_front();
      total_cnt++;
      if (hex_out !== e)
        $display("FAIL full_wr got %h want %h", hex_out, e);
      else pass_cnt++;
    end
    repeat (3) begin
      set_in(1, 5'h15, 0);
      total_cnt++;
      if (wr_if.wr_ready !== 1'b0)
        $display("FAIL full_hold got %b want 0",
                 wr_if.wr_ready);
      else pass_cnt++;
      clk_step();
      e = exp_q.pop_front();
      total_cnt++;
      if (msg_len !== 5'd16)
        $display("FAIL full_len got %0d want 16", msg_len);
      else pass_cnt++;
    end
    set_in(0, 5'd0, 0);
    for (int n = 0; n <= 68; n++) begin
      scroll_cycle(n);
      e = exp_q.pop_front();
      total_cnt++;
      if (hex_out !== e)
        $display("FAIL full_scroll n=%0d got %h want %h",
                 n, hex_out, e);
      else pass_cnt++;
    end
    leave_mode();
  endtask

  task automatic test_scroll();
    set_in(0, 5'd0, 1);
    clk_step();
    e = exp_q.pop_front();
    for (int i = 0; i < 8; i++) begin
      set_in(1, 5'(i), 0);
      clk_step();
      e = exp_q.pop_front();
      total_cnt++;
      if (hex_out !== e)
        $display("FAIL scroll_fill got %h want %h", hex_out, e);
      else pass_cnt++;
    end
    set_in(0, 5'd0, 0);
    for (int n = 0; n <= 36; n++) begin
      scroll_cycle(n);
      e = exp_q.pop_front();
      total_cnt++;
      if (hex_out !== e)
        $display("FAIL scroll n=%0d got %h want %h",
                 n, hex_out, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (hex_out[47:40] !== 8'hC0)
      $display("FAIL scroll_wrap got %h want c0",
               hex_out[47:40]);
    else pass_cnt++;
    leave_mode();
  endtask

  task automatic test_blink();
    logic [4:0] txt [3];
    bit on;
    txt[0] = 5'h0A;
    txt[1] = 5'h12;
    txt[2] = 5'h14;
    set_in(0, 5'd0, 1);
    clk_step();
    e = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      set_in(1, txt[i], 0);
      clk_step();
      e = exp_q.pop_front();
      total_cnt++;
      if (hex_out !== e)
        $display("FAIL blink_fill got %h want %h", hex_out, e);
      else pass_cnt++;
    end
    set_in(0, 5'd0, 0);
    dp_in = 6'b000001;
    for (int n = 0; n < 12; n++) begin
      mode = 2'd1;
      on = (n == 0) || ((((n - 1) / 3) % 2) == 0);
      exp_q.push_back(on ? render(0, dp_in) : {48{1'b1}});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      total_cnt++;
      if (hex_out !== e)
        $display("FAIL blink n=%0d got %h want %h",
                 n, hex_out, e);
      else pass_cnt++;
    end
    mode = 2'd0;
    exp_q.push_back(render(0, dp_in));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    total_cnt++;
    if (hex_out !== e)
      $display("FAIL blink_restore got %h want %h", hex_out, e);
    else pass_cnt++;
    total_cnt++;
    if (hex_out[7] !== 1'b0)
      $display("FAIL blink_dp got %b want 0", hex_out[7]);
    else pass_cnt++;
    dp_in = '0;
  endtask

  task automatic test_reset_mid_scroll();
    set_in(0, 5'd0, 1);
    clk_step();
    e = exp_q.pop_front();
    for (int i = 0; i < 8; i++) begin
      set_in(1, 5'(i), 0);
      clk_step();
      e = exp_q.pop_front();
    end
    set_in(0, 5'd0, 0);
    for (int n = 0; n <= 21; n++) begin
      scroll_cycle(n);
      e = exp_q.pop_front();
      total_cnt++;
      if (hex_out !== e)
        $display("FAIL mid_scroll n=%0d got %h want %h",
                 n, hex_out, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (hex_out[47:40] !== 8'h92)
      $display("FAIL mid_off5 got %h want 92", hex_out[47:40]);
    else pass_cnt++;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    m_len = 0;
    total_cnt++;
    if (hex_out !== {6{8'hFF}})
      $display("FAIL mid_rst_hex got %h want %h",
               hex_out, {6{8'hFF}});
    else pass_cnt++;
    total_cnt++;
    if (msg_len !== 5'd0)
      $display("FAIL mid_rst_len got %0d want 0", msg_len);
    else pass_cnt++;
    total_cnt++;
    if (wr_if.wr_ready !== 1'b0)
      $display("FAIL mid_rst_ready got %b want 0",
               wr_if.wr_ready);
    else pass_cnt++;
    mode  = 2'd0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (wr_if.wr_ready !== 1'b1)
      $display("FAIL mid_release_ready got %b want 1",
               wr_if.wr_ready);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_static();
    test_clr_collision();
    test_full();
    test_scroll();
    test_blink();
    test_reset_mid_scroll();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
